reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width.
REQ-002 Parameter NREGS, default 2**ADDR_W: number of tracked registers, fixed at 2**ADDR_W.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 iss_valid  input  1  an instruction requests to claim a destination register.
REQ-006 iss_addr  input  ADDR_W  destination register being claimed.
REQ-007 iss_ready  output  1  the claim is accepted this cycle; combinational.
REQ-008 wb_valid  input  1  writeback releases a register.
REQ-009 wb_addr  input  ADDR_W  register being released.
REQ-010 rs_addr, rt_addr  input  ADDR_W each  source operands to check.
REQ-011 rs_busy, rt_busy  output  1 each  source operand has a pending write; combinational.
REQ-012 busy_vec  output  NREGS  registered busy bits, bit i = register i.
REQ-013 busy_count  output  ADDR_W+1  registered population count of busy_vec.
REQ-014 wb_err  output  1  sticky flag: a writeback targeted a non-busy register.

Function
REQ-015 Accept an issue (fire) when iss_valid=1, iss_ready=1 and iss_addr!=0.
REQ-016 iss_ready = !busy_vec[iss_addr] OR (wb_valid AND wb_addr==iss_addr); iss_ready=1 for iss_addr=0.
REQ-017 On fire, set busy_vec[iss_addr] at the next clk edge using a one-hot decode of iss_addr.
REQ-018 When wb_valid=1 and wb_addr!=0, clear busy_vec[wb_addr] at the next clk edge.
REQ-019 When a fire and a wb_valid target the same address in one cycle, the set wins; the bit stays 1.
REQ-020 When a fire and a wb_valid target different addresses in one cycle, both updates take effect at the same edge.
REQ-021 busy_vec[0] is constant 0; issues and writebacks to address 0 are ignored.
REQ-022 rs_busy = busy_vec[rs_addr] AND NOT (wb_valid AND wb_addr==rs_addr); rt_busy is defined the same way; both are 0 for address 0.
REQ-023 Latency: a claim is visible on busy_vec and rs_busy/rt_busy 1 cycle after fire; a writeback bypass is visible on rs_busy/rt_busy in the same cycle.
REQ-024 busy_count equals popcount(busy_vec) in the same cycle, registered alongside busy_vec; range 0..NREGS-1.
REQ-025 Set wb_err at the next edge when wb_valid=1, wb_addr!=0 and busy_vec[wb_addr]=0; wb_err never self-clears.
REQ-026 A writeback to a non-busy register leaves busy_vec unchanged except for REQ-019.

Reset
REQ-027 reset_n=0 asynchronously forces busy_vec=0, busy_count=0 and wb_err=0.
REQ-028 Reset asserted mid-operation discards all pending claims; the first edge after release behaves as if no prior history existed.
REQ-029 During reset, iss_ready, rs_busy and rt_busy follow REQ-016/REQ-022 with busy_vec=0.

Structure
REQ-030 Shared package holds the ADDR_W default, a reg_addr_t typedef and a REG_ZERO constant (0).
REQ-031 One sub-module, decoder_n: parametrised ADDR_W to 2**ADDR_W one-hot decoder with an enable input, instantiated twice (set and clear masks).
REQ-032 busy_vec next state = (busy_vec AND NOT clr_mask) OR set_mask, with bit 0 forced to 0.

Verification
REQ-033 Reset, then iss 5 -> iss_ready=1; next cycle busy_vec=0x00000020, busy_count=1, rs_addr=5 gives rs_busy=1.
REQ-034 Reg 5 busy, iss 5 without wb -> iss_ready=0, busy_count stays 1; same with wb 5 -> iss_ready=1, bit 5 remains 1, busy_count=1.
REQ-035 Reg 7 busy, wb 7 with rt_addr=7 -> rt_busy=0 same cycle; next cycle busy_vec bit7=0, busy_count=0, wb_err=0.
REQ-036 Reset, then wb 9 -> wb_err=1 next cycle and stays 1 after subsequent valid traffic; iss 0 -> busy_vec stays 0.
REQ-037 Claim regs 1..31 one per cycle -> busy_count=31 and busy_vec=0xFFFFFFFE; assert reset_n=0 mid-sequence -> outputs 0 immediately, without waiting for clk.
REQ-038 Random issue/writeback traffic with a reference model -> busy_vec, busy_count and wb_err match every cycle for ADDR_W=3 and ADDR_W=5.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: default address width,
// register-address type and the hard-wired zero register.
package reg_scoreboard_pkg;

    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard_decoder_n.sv
// Enabled binary-to-one-hot decoder; output is all zeros when en is low.
module decoder_n #(
    parameter int ADDR_W = 5
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks destination registers with a pending write,
// with same-cycle writeback bypass on the operand and issue checks.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [NREGS-1:0]  busy_vec,
    output logic [ADDR_W:0]   busy_count,
    output logic              wb_err
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic             fire;
    logic             wb_clr;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy_nxt;

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // A register being released this cycle may be reclaimed immediately.
    assign iss_ready = (iss_addr == ZERO) || !busy_vec[iss_addr]
                       || (wb_valid && (wb_addr == iss_addr));
    assign fire      = iss_valid && iss_ready && (iss_addr != ZERO);
    assign wb_clr    = wb_valid && (wb_addr != ZERO);

    // Bit 0 is never set, so register 0 reads as not busy without a special case.
    assign rs_busy = busy_vec[rs_addr] && !(wb_valid && (wb_addr == rs_addr));
    assign rt_busy = busy_vec[rt_addr] && !(wb_valid && (wb_addr == rt_addr));

    decoder_n #(.ADDR_W(ADDR_W)) u_set_dec (
        .en     (fire),
        .addr   (iss_addr),
        .onehot (set_mask)
    );

    decoder_n #(.ADDR_W(ADDR_W)) u_clr_dec (
        .en     (wb_clr),
        .addr   (wb_addr),
        .onehot (clr_mask)
    );

    // Set is OR'd after the clear so a same-address claim wins over a release.
    always_comb begin
        busy_nxt    = (busy_vec & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec   <= '0;
            busy_count <= '0;
            wb_err     <= 1'b0;
        end else begin
            busy_vec   <= busy_nxt;
            busy_count <= popcount(busy_nxt);
            if (wb_clr && !busy_vec[wb_addr]) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic against a behavioural model for ADDR_W=5 and ADDR_W=3.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        iss_valid, wb_valid;
    logic [4:0]  iss_addr, wb_addr, rs_addr, rt_addr;
    logic        iss_ready, rs_busy, rt_busy, wb_err;
    logic [31:0] busy_vec;
    logic [5:0]  busy_count;

    logic        s_iss_valid, s_wb_valid;
    logic [2:0]  s_iss_addr, s_wb_addr, s_rs_addr, s_rt_addr;
    logic        s_iss_ready, s_rs_busy, s_rt_busy, s_wb_err;
    logic [7:0]  s_busy_vec;
    logic [3:0]  s_busy_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .busy_vec(busy_vec), .busy_count(busy_count), .wb_err(wb_err)
    );

    reg_scoreboard #(.ADDR_W(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .iss_valid(s_iss_valid), .iss_addr(s_iss_addr), .iss_ready(s_iss_ready),
        .wb_valid(s_wb_valid), .wb_addr(s_wb_addr),
        .rs_addr(s_rs_addr), .rt_addr(s_rt_addr), .rs_busy(s_rs_busy), .rt_busy(s_rt_busy),
        .busy_vec(s_busy_vec), .busy_count(s_busy_count), .wb_err(s_wb_err)
    );

    task automatic idle();
        iss_valid = 0; iss_addr = 0; wb_valid = 0; wb_addr = 0; rs_addr = 0; rt_addr = 0;
        s_iss_valid = 0; s_iss_addr = 0; s_wb_valid = 0; s_wb_addr = 0; s_rs_addr = 0; s_rt_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        iss_addr = 5'd3; rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_vec: got %h expected 0", busy_vec); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", busy_count); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", wb_err); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", iss_ready); end
        checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin errors++; $display("FAIL reset_src: got %b%b expected 00", rs_busy, rt_busy); end
        tick();
        reset_n = 1;
        idle();
        #1;
    endtask

    task automatic test_claim();
        iss_valid = 1; iss_addr = 5'd5;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL claim_ready: got %b expected 1", iss_ready); end
        tick();
        iss_valid = 0; rs_addr = 5'd5;
        #1;
        checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL claim_vec: got %h expected 00000020", busy_vec); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL claim_count: got %0d expected 1", busy_count); end
        checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL claim_rs_busy: got %b expected 1", rs_busy); end
    endtask

    task automatic test_conflict();
        idle();
        iss_valid = 1; iss_addr = 5'd5;
        #1;
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready: got %b expected 0", iss_ready); end
        tick();
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL conflict_count: got %0d expected 1", busy_count); end
        wb_valid = 1; wb_addr = 5'd5;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL conflict_bypass_ready: got %b expected 1", iss_ready); end
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL setwins_vec: got %h expected 00000020", busy_vec); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL setwins_count: got %0d expected 1", busy_count); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL setwins_err: got %b expected 0", wb_err); end
    endtask

    task automatic test_bypass();
        do_reset();
        iss_valid = 1; iss_addr = 5'd7;
        tick();
        idle();
        rt_addr = 5'd7;
        #1;
        checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL bypass_pre: got %b expected 1", rt_busy); end
        wb_valid = 1; wb_addr = 5'd7;
        #1;
        checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL bypass_rt: got %b expected 0", rt_busy); end
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL release_vec: got %h expected 0", busy_vec); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL release_count: got %0d expected 0", busy_count); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL release_err: got %b expected 0", wb_err); end
    endtask

    task automatic test_wb_err();
        do_reset();
        wb_valid = 1; wb_addr = 5'd9;
        tick();
        idle();
        #1;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wberr_set: got %b expected 1", wb_err); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL wberr_vec: got %h expected 0", busy_vec); end
        iss_valid = 1; iss_addr = 5'd0;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", iss_ready); end
        tick();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL zero_vec: got %h expected 0", busy_vec); end
        iss_addr = 5'd3;
        tick();
        iss_valid = 0; wb_valid = 1; wb_addr = 5'd3;
        tick();
        idle();
        #1;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wberr_sticky: got %b expected 1", wb_err); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL wberr_traffic_vec: got %h expected 0", busy_vec); end
    endtask

    task automatic test_fill();
        int nrdy;
        do_reset();
        nrdy = 0;
        for (int a = 1; a < 32; a++) begin
            iss_valid = 1; iss_addr = 5'(a);
            #1;
            if (iss_ready !== 1'b1) nrdy++;
            tick();
        end
        idle();
        #1;
        checks++; if (nrdy != 0) begin errors++; $display("FAIL fill_ready: got %0d stalls expected 0", nrdy); end
        checks++; if (busy_count !== 6'd31) begin errors++; $display("FAIL fill_count: got %0d expected 31", busy_count); end
        checks++; if (busy_vec !== 32'hFFFF_FFFE) begin errors++; $display("FAIL fill_vec: got %h expected FFFFFFFE", busy_vec); end
        // Reset mid-sequence, away from the clock edge.
        do_reset();
        for (int a = 1; a <= 10; a++) begin
            iss_valid = 1; iss_addr = 5'(a);
            tick();
        end
        #2;
        reset_n = 0;
        #1;
        checks++; if (busy_vec !== 32'h0 || busy_count !== 6'd0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL async_reset: got vec=%h cnt=%0d err=%b expected 0", busy_vec, busy_count, wb_err);
        end
        tick();
        reset_n = 1;
        iss_valid = 1; iss_addr = 5'd4;
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0000_0010 || busy_count !== 6'd1) begin
            errors++; $display("FAIL post_reset: got vec=%h cnt=%0d expected 00000010/1", busy_vec, busy_count);
        end
    endtask

    task automatic test_random(input int aw, input int cycles);
        int n, ia, wa, ra, ta, cnt;
        bit iv, wv, exp_ready, exp_rs, exp_rt, merr;
        bit mbusy[32];
        int bq[$];
        logic        o_ready, o_rs, o_rt, o_err;
        logic [31:0] o_vec, e_vec;
        logic [5:0]  o_cnt;
        n = 1 << aw;
        do_reset();
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
        merr = 0;
        for (int c = 0; c < cycles; c++) begin
            iv = ($urandom_range(0, 3) != 0);
            ia = int'($urandom_range(0, n - 1));
            wv = ($urandom_range(0, 1) == 1);
            bq.delete();
            for (int i = 1; i < n; i++) if (mbusy[i]) bq.push_back(i);
            if ($urandom_range(0, 7) == 0) wa = ia;
            else if (bq.size() > 0 && $urandom_range(0, 15) != 0) wa = bq[$urandom_range(0, bq.size() - 1)];
            else wa = int'($urandom_range(0, n - 1));
            ra = int'($urandom_range(0, n - 1));
            ta = (bq.size() > 0) ? bq[$urandom_range(0, bq.size() - 1)] : int'($urandom_range(0, n - 1));
            idle();
            if (aw == 5) begin
                iss_valid = iv; iss_addr = 5'(ia); wb_valid = wv; wb_addr = 5'(wa);
                rs_addr = 5'(ra); rt_addr = 5'(ta);
            end else begin
                s_iss_valid = iv; s_iss_addr = 3'(ia); s_wb_valid = wv; s_wb_addr = 3'(wa);
                s_rs_addr = 3'(ra); s_rt_addr = 3'(ta);
            end
            #1;
            exp_ready = (ia == 0) || !mbusy[ia] || (wv && wa == ia);
            exp_rs = (ra != 0) && mbusy[ra] && !(wv && wa == ra);
            exp_rt = (ta != 0) && mbusy[ta] && !(wv && wa == ta);
            if (aw == 5) begin o_ready = iss_ready; o_rs = rs_busy; o_rt = rt_busy; end
            else begin o_ready = s_iss_ready; o_rs = s_rs_busy; o_rt = s_rt_busy; end
            checks++; if (o_ready !== exp_ready) begin errors++; $display("FAIL rand%0d_ready c=%0d: got %b expected %b", aw, c, o_ready, exp_ready); end
            checks++; if (o_rs !== exp_rs || o_rt !== exp_rt) begin
                errors++; $display("FAIL rand%0d_src c=%0d: got %b%b expected %b%b", aw, c, o_rs, o_rt, exp_rs, exp_rt);
            end
            if (wv && wa != 0) begin
                if (!mbusy[wa]) merr = 1;
                mbusy[wa] = 0;
            end
            if (iv && exp_ready && ia != 0) mbusy[ia] = 1;
            tick();
            e_vec = '0; cnt = 0;
            for (int i = 0; i < n; i++) begin e_vec[i] = mbusy[i]; cnt += int'(mbusy[i]); end
            if (aw == 5) begin o_vec = busy_vec; o_cnt = busy_count; o_err = wb_err; end
            else begin o_vec = {24'h0, s_busy_vec}; o_cnt = {2'b0, s_busy_count}; o_err = s_wb_err; end
            checks++; if (o_vec !== e_vec || o_cnt !== 6'(cnt) || o_err !== merr) begin
                errors++; $display("FAIL rand%0d_state c=%0d: got vec=%h cnt=%0d err=%b expected vec=%h cnt=%0d err=%b",
                                   aw, c, o_vec, o_cnt, o_err, e_vec, cnt, merr);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_claim();
        test_conflict();
        test_bypass();
        test_wb_err();
        test_fill();
        test_random(5, 600);
        test_random(3, 600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
